// File: rtl/window_trend_counter.sv
// window_trend_counter: counts sliding-window sum trend hits by comparing each new sample to the one leaving the window
module window_trend_counter #(
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW      = 3,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTN,
  input  logic                   I_CLEAR,
  input  logic [1:0]             I_MODE,
  input  logic                   I_VALID,
  output logic                   O_READY,
  input  logic [DATA_WIDTH-1:0]  I_DATA,
  input  logic                   I_LAST,
  output logic [COUNT_WIDTH-1:0] O_COUNT,
  output logic                   O_SAT,
  output logic                   O_DONE
);
  localparam int FW = $clog2(WINDOW + 1);
  localparam int SW = WINDOW * DATA_WIDTH;
  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [SW-1:0] win_q, win_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic sat_q, sat_d;
  logic accept, hit;
  logic [DATA_WIDTH-1:0] oldest;
  assign O_READY = state_q != DONE;
  assign O_DONE  = state_q == DONE;
  assign O_COUNT = count_q;
  assign O_SAT   = sat_q;
  assign accept  = I_VALID & O_READY;
  assign oldest  = win_q[SW-1 -: DATA_WIDTH];
  always_comb begin
    hit = I_MODE == 2'd0 ? I_DATA > oldest :
          I_MODE == 2'd1 ? I_DATA < oldest :
          I_MODE == 2'd2 ? I_DATA == oldest : I_DATA >= oldest;
  end
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    win_d   = win_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (accept) begin
      win_d = SW'({win_q, I_DATA});
      if (state_q == FILL) begin
        fill_d  = fill_q + FW'(1);
        state_d = fill_q == FW'(WINDOW - 1) ? RUN : FILL;
      end else if (hit) begin
        count_d = &count_q ? count_q : count_q + COUNT_WIDTH'(1);
        sat_d   = sat_q | (&count_q);
      end
      if (I_LAST) state_d = DONE;
    end
  end
  always_ff @(posedge I_CLK) begin
    if (!I_RSTN || I_CLEAR) begin
      state_q <= FILL;
      fill_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end
  always_ff @(posedge I_CLK) win_q <= win_d;
endmodule

// File: tb/tb_window_trend_counter.sv
// tb_window_trend_counter: directed checks of window_trend_counter at WINDOW 1 and 3 and a 2-bit saturating count
module tb_window_trend_counter;
  logic clk = 1'b0;
  logic rstn, clear, valid, last;
  logic [1:0] mode;
  logic [31:0] data;
  logic rdy1, rdy3, rdyc, sat1, sat3, satc, done1, done3, donec;
  logic [31:0] cnt1, cnt3;
  logic [1:0] cntc;
  int checks = 0;
  int errors = 0;
  int stream [10] = '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263};
  always #5 clk = ~clk;
  window_trend_counter #(.DATA_WIDTH(32), .WINDOW(1), .COUNT_WIDTH(32)) u_w1 (
    .I_CLK(clk), .I_RSTN(rstn), .I_CLEAR(clear), .I_MODE(mode), .I_VALID(valid), .O_READY(rdy1),
    .I_DATA(data), .I_LAST(last), .O_COUNT(cnt1), .O_SAT(sat1), .O_DONE(done1));
  window_trend_counter #(.DATA_WIDTH(32), .WINDOW(3), .COUNT_WIDTH(32)) u_w3 (
    .I_CLK(clk), .I_RSTN(rstn), .I_CLEAR(clear), .I_MODE(mode), .I_VALID(valid), .O_READY(rdy3),
    .I_DATA(data), .I_LAST(last), .O_COUNT(cnt3), .O_SAT(sat3), .O_DONE(done3));
  window_trend_counter #(.DATA_WIDTH(32), .WINDOW(1), .COUNT_WIDTH(2)) u_c2 (
    .I_CLK(clk), .I_RSTN(rstn), .I_CLEAR(clear), .I_MODE(mode), .I_VALID(valid), .O_READY(rdyc),
    .I_DATA(data), .I_LAST(last), .O_COUNT(cntc), .O_SAT(satc), .O_DONE(donec));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask
  task automatic run_stream(input int gaps);
    for (int i = 0; i < 10; i++) begin
      if (gaps != 0) repeat ($urandom_range(0, 3)) tick();
      if (i == 9) chk("done_before_last", {31'd0, done1}, 32'd0);
      send(stream[i], i == 9);
    end
  endtask
  initial begin
    rstn = 1'b0; clear = 1'b0; valid = 1'b0; last = 1'b0; mode = 2'd0; data = '0;
    do_reset();
    chk("rst_count", cnt3, 0);
    chk("rst_sat", {31'd0, sat3}, 0);
    chk("rst_done", {31'd0, done3}, 0);
    chk("rst_ready", {31'd0, rdy3}, 1);
    run_stream(0);
    chk("t1_w1_count", cnt1, 7);
    chk("t1_w1_done", {31'd0, done1}, 1);
    chk("t2_w3_count", cnt3, 5);
    do_reset();
    run_stream(1);
    chk("t2_gap_w3_count", cnt3, 5);
    chk("t2_gap_w1_count", cnt1, 7);
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send(i, 1'b0);
      if (i == 4) begin
        chk("t3_cnt_at4", {30'd0, cntc}, 3);
        chk("t3_sat_at4", {31'd0, satc}, 0);
      end
      if (i == 5) chk("t3_sat_at5", {31'd0, satc}, 1);
    end
    chk("t3_cnt_end", {30'd0, cntc}, 3);
    chk("t3_sat_end", {31'd0, satc}, 1);
    do_reset();
    mode = 2'd1;
    run_stream(0);
    chk("t4_mode1", cnt1, 2);
    do_reset();
    mode = 2'd2;
    send(5, 0); send(5, 0); send(5, 1);
    chk("t4_mode2", cnt1, 2);
    do_reset();
    mode = 2'd3;
    send(5, 0); send(5, 0); send(6, 1);
    chk("t4_mode3", cnt1, 2);
    chk("t5_ready_done", {31'd0, rdy1}, 0);
    send(100, 0);
    chk("t5_done_ignore", cnt1, 2);
    chk("t5_done_held", {31'd0, done1}, 1);
    mode = 2'd0;
    clear = 1'b1;
    send(1, 0);
    clear = 1'b0;
    chk("t5_clr_count", cnt1, 0);
    chk("t5_clr_done", {31'd0, done1}, 0);
    chk("t5_clr_ready", {31'd0, rdy1}, 1);
    send(100, 0); send(200, 0);
    chk("t5_clr_dropped", cnt1, 1);
    do_reset();
    send(1, 0); send(2, 0); send(3, 0); send(9, 0);
    chk("t6_pre_reset", cnt3, 1);
    do_reset();
    chk("t6_rst_count", cnt3, 0);
    chk("t6_rst_sat", {31'd0, sat3}, 0);
    chk("t6_rst_done", {31'd0, done3}, 0);
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    chk("t6_count", cnt3, 1);
    send(5, 1);
    chk("t6_last_count", cnt3, 1);
    chk("t6_last_done", {31'd0, done3}, 1);
    do_reset();
    send(7, 1);
    tick();
    chk("first_last_count", cnt3, 0);
    chk("first_last_done", {31'd0, done3}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
